// File: rtl/ahb_pkg.sv
// ahb_pkg -- shared AHB encodings for the single-slave memory.
// Contents:
//   HTRANS_* : transfer type codes driven by the master.
//   HRESP_*  : slave response codes (only OKAY and ERROR are ever driven).
//   state_e  : data-phase FSM states of ahb_slave_mem.
//   is_active_trans() : true for transfer types that open a data phase.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // IDLE and BUSY never carry a data phase; only NONSEQ and SEQ do.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// ahb_slave_ram -- MEM_WORDS x 32 storage array for ahb_slave_mem.
// One synchronous write port and one asynchronous read port.
// Ports:
//   clk   : clock, writes happen on the rising edge.
//   we    : write enable.
//   waddr : word index for the write.
//   wdata : write data.
//   raddr : word index for the combinational read.
//   rdata : read data for raddr.
// Contents are never reset.
module ahb_slave_ram
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem -- AHB slave fronting a MEM_WORDS x 32 memory with a fixed
// number of wait states per OKAY data phase and a two-cycle ERROR response.
// Ports:
//   hclk       : clock, all logic on the rising edge.
//   hreset     : synchronous active-high reset.
//   hsel       : slave select from the address decoder.
//   haddr      : byte address (address phase).
//   hwrite     : 1 = write, 0 = read (address phase).
//   htrans     : transfer type (address phase).
//   hwdata     : write data (data phase).
//   hready_in  : bus HREADY; equals hready_out when this is the only slave.
//   hready_out : high ends the current data phase.
//   hresp      : OKAY or ERROR.
//   hrdata     : read data, zero outside the final cycle of a read.
// Configuration macro AHB_SLAVE_ERR_EN: when defined, unaligned and
// out-of-range accesses get an ERROR response and have no effect; when
// undefined, the word index wraps modulo MEM_WORDS and hresp stays OKAY.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int         IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;

  logic             accept;
  logic             addr_err;
  logic             ram_we;
  logic [31:0]      ram_rdata;

  assign accept = hsel && hready_in && is_active_trans(htrans);

`ifdef AHB_SLAVE_ERR_EN
  // Word index is compared at full width so addresses far above the
  // array are caught rather than aliased.
  assign addr_err = (haddr[1:0] != 2'b00) ||
                    ({2'b00, haddr[31:2]} >= 32'(MEM_WORDS));
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{haddr[31:IDX_W+2], haddr[1:0]};
`endif

  // Next-state logic. IDLE, DATA and ERR2 all end with hready_out high,
  // so they share the address-phase accept path; that is what lets
  // back-to-back transfers run without a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        if (accept) begin
          idx_d   = haddr[IDX_W+1:2];
          write_d = hwrite;
          if (addr_err) begin
            state_d = ST_ERR1;
            cnt_d   = 3'd0;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_DATA;
            cnt_d   = 3'd0;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  // The write lands on the edge that closes the data phase; gating with
  // hreset drops a write that is cut short by reset.
  assign ram_we = (state_q == ST_DATA) && write_q && !hreset;

  ahb_slave_ram #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk   (hclk),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (hwdata),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

  assign hready_out = !((state_q == ST_WAIT) || (state_q == ST_ERR1));

`ifdef AHB_SLAVE_ERR_EN
  assign hresp = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign hresp = HRESP_OKAY;
`endif

  assign hrdata = ((state_q == ST_DATA) && !write_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem -- self-checking bench for ahb_slave_mem with
// MEM_WORDS=256 and WAIT_STATES=1, hready_in tied to hready_out.
// A small AHB master drives queued requests; each accepted transfer pushes
// its expected response onto a scoreboard, popped when its data phase runs.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  localparam int WS        = 1;
  localparam int MEM_WORDS = 256;
  localparam int SEQ_LIMIT = 2000;

  logic        hclk;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          write;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  req_t        reqs[$];
  exp_t        sb[$];
  logic [31:0] model [MEM_WORDS];
  int          checks   = 0;
  int          failures = 0;

  ahb_slave_mem #(
    .MEM_WORDS   (MEM_WORDS),
    .WAIT_STATES (WS)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hsel       (hsel),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .htrans     (htrans),
    .hwdata     (hwdata),
    .hready_in  (hready),
    .hready_out (hready),
    .hresp      (hresp),
    .hrdata     (hrdata)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Hard stop in case anything above the cycle budgets stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference behaviour of the error flag and word index.
  function automatic bit modelErr(input logic [31:0] a);
`ifdef AHB_SLAVE_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'h0000_0400);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int modelIdx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic addReq(input bit sel, input logic [1:0] trans, input bit write,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.sel   = sel;
    r.trans = trans;
    r.write = write;
    r.addr  = addr;
    r.wdata = wdata;
    reqs.push_back(r);
  endtask

  // Runs every queued request through the bus as a pipelined master.
  // Inputs change #1 after the rising edge; outputs are sampled on the
  // falling edge. An address phase is taken by the slave when hready is
  // high in its cycle, which is when the expected result is pushed.
  task automatic applyStimulus();
    bit   dp_active = 1'b0;
    exp_t cur;
    int   waits  = 0;
    int   budget = 0;
    while ((reqs.size() > 0 || dp_active) && budget < SEQ_LIMIT) begin
      budget++;
      if (reqs.size() > 0) begin
        hsel   = reqs[0].sel;
        htrans = reqs[0].trans;
        hwrite = reqs[0].write;
        haddr  = reqs[0].addr;
      end else begin
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        haddr  = 32'h0;
      end
      hwdata = dp_active ? cur.wdata : 32'h0;
      @(negedge hclk);
      if (dp_active) begin
        if (!hready) begin
          waits++;
          checkOutput("wait_hresp", 32'(hresp), cur.err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
          checkOutput("wait_hrdata", hrdata, 32'h0);
        end else begin
          checkOutput("wait_cycles", 32'(waits), cur.err ? 32'd1 : 32'(WS));
          checkOutput("data_hresp", 32'(hresp), cur.err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
          checkOutput("data_hrdata", hrdata, cur.rdata);
          dp_active = 1'b0;
        end
      end else begin
        checkOutput("idle_hready", 32'(hready), 32'd1);
        checkOutput("idle_hresp", 32'(hresp), 32'(HRESP_OKAY));
        checkOutput("idle_hrdata", hrdata, 32'h0);
      end
      if (hready && reqs.size() > 0) begin : take_addr
        req_t r;
        exp_t e;
        r = reqs.pop_front();
        if (r.sel && (r.trans == HTRANS_NONSEQ || r.trans == HTRANS_SEQ)) begin
          e.write = r.write;
          e.err   = modelErr(r.addr);
          e.wdata = r.wdata;
          e.rdata = 32'h0;
          if (!e.err) begin
            if (r.write) model[modelIdx(r.addr)] = r.wdata;
            else         e.rdata = model[modelIdx(r.addr)];
          end
          sb.push_back(e);
        end
      end
      @(posedge hclk);
      #1;
      if (!dp_active && sb.size() > 0) begin
        cur       = sb.pop_front();
        dp_active = 1'b1;
        waits     = 0;
      end
    end
    checkOutput("sequence_done", 32'(reqs.size()) + 32'(dp_active), 32'h0);
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hwdata = 32'h0;
  endtask

  // Starts a write of 0x55 to 0x08, asserts reset while it is waiting,
  // and checks the slave comes back idle. The model is left untouched.
  task automatic resetMidWrite();
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    haddr  = 32'h08;
    hwdata = 32'h0;
    @(negedge hclk);
    checkOutput("rst_addr_hready", 32'(hready), 32'd1);
    @(posedge hclk);
    #1;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hwdata = 32'h55;
    hreset = 1'b1;
    @(negedge hclk);
    checkOutput("rst_in_wait_hready", 32'(hready), 32'd0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    hwdata = 32'h0;
    @(negedge hclk);
    checkOutput("rst_after_hready", 32'(hready), 32'd1);
    checkOutput("rst_after_hresp", 32'(hresp), 32'(HRESP_OKAY));
    checkOutput("rst_after_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    #1;
  endtask

  // Main sequence: reset, directed scenarios, random pipelined traffic,
  // then reset during a pending write.
  initial begin
    hreset = 1'b1;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hwdata = 32'h0;
    repeat (2) @(posedge hclk);
    #1;
    @(negedge hclk);
    checkOutput("reset_hready", 32'(hready), 32'd1);
    checkOutput("reset_hresp", 32'(hresp), 32'(HRESP_OKAY));
    checkOutput("reset_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;

    $display("[TB] write then read 0x10");
    addReq(1, HTRANS_NONSEQ, 1, 32'h10, 32'hDEADBEEF);
    applyStimulus();
    addReq(1, HTRANS_NONSEQ, 0, 32'h10, 32'h0);
    applyStimulus();

    $display("[TB] back-to-back write/read of 0x20");
    addReq(1, HTRANS_NONSEQ, 1, 32'h20, 32'hA5A5A5A5);
    addReq(1, HTRANS_SEQ,    0, 32'h20, 32'h0);
    applyStimulus();

    $display("[TB] out-of-range accesses at 0x400");
    addReq(1, HTRANS_NONSEQ, 1, 32'h00, 32'hCAFE0000);
    addReq(1, HTRANS_NONSEQ, 0, 32'h400, 32'h0);
    addReq(1, HTRANS_NONSEQ, 1, 32'h400, 32'hBAD0BAD0);
    addReq(1, HTRANS_NONSEQ, 0, 32'h00, 32'h0);
    applyStimulus();

    $display("[TB] unaligned write to 0x13");
    addReq(1, HTRANS_NONSEQ, 1, 32'h13, 32'h11111111);
    addReq(1, HTRANS_NONSEQ, 0, 32'h10, 32'h0);
    applyStimulus();

    $display("[TB] BUSY and unselected cycles");
    addReq(1, HTRANS_NONSEQ, 1, 32'h30, 32'h30303030);
    addReq(1, HTRANS_BUSY,   1, 32'h30, 32'h0);
    addReq(0, HTRANS_NONSEQ, 1, 32'h30, 32'h0);
    addReq(1, HTRANS_NONSEQ, 0, 32'h30, 32'h0);
    applyStimulus();

    $display("[TB] random pipelined traffic");
    for (int i = 0; i < 16; i++) begin
      addReq(1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1, 32'h40 + 32'(4 * i),
             32'h01010101 * 32'(i + 1));
    end
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      int          pick;
      pick = int'($urandom_range(0, 5));
      if (pick == 0)      a = 32'h402;
      else if (pick == 1) a = 32'h41;
      else                a = 32'h40 + 32'(4 * $urandom_range(0, 15));
      addReq(1, ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ,
             ($urandom_range(0, 1) == 1), a, $urandom());
    end
    applyStimulus();

    $display("[TB] reset during a pending write to 0x08");
    addReq(1, HTRANS_NONSEQ, 1, 32'h08, 32'h12345678);
    applyStimulus();
    resetMidWrite();
    addReq(1, HTRANS_NONSEQ, 0, 32'h08, 32'h0);
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
